xt_keyboard_port: RTL and testbench

Downstream stage of the PS/2 keyboard receiver/converter in the PC/XT core. Takes each XT (set 1) keycode presented on the receiver's `irq`/`keycode` pair and acknowledges it at once through `clear_keycode`, so a second byte never collides with an unacknowledged one. Buffers codes in a small FIFO and presents them to 8255 port A one at a time with IRQ1, using the XT port B handshake: PB7 clears the latch, and PB6 held low performs a keyboard reset.

---
 rtl/xt_keyboard_port.sv | 228 ++++++++++++++++++++++
 tb/tb_xt_keyboard_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xt_keyboard_port.sv
`default_nettype none
// ============================================================================
//  Module   : xt_keyboard_port
//  Purpose  : XT keyboard interface stage. Acknowledges every keycode that the
//             PS/2 receiver presents, buffers the codes in a small FIFO, and
//             hands them one at a time to 8255 port A with IRQ1. The XT port B
//             handshake is honoured: PB7 clears the latch, and a long PB6 low
//             pulse performs a keyboard reset.
//  Ports    : clock, reset_n             - core clock, async active-low reset
//             kb_irq, kb_keycode         - keycode valid / value from receiver
//             kb_clear_keycode           - one-cycle acknowledge to receiver
//             port_clear (PB7)           - clears latch, blocks loading
//             port_clock_n (PB6)         - low holds keyboard clock low
//             port_a_data, irq1          - latched code and interrupt request
//             overflow                   - sticky "code dropped" flag
//             fifo_count                 - current FIFO occupancy
//  Config   : XT_KBD_SELF_TEST_EN - a qualified keyboard reset queues 8'hAA
//             into the flushed FIFO (self-test passed code).
//  Revision : 1.0 - initial release
// ============================================================================
module xt_keyboard_port #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] RESET_HOLD = 16'd20000,
    parameter logic [15:0] LOAD_GAP   = 16'd100
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          kb_irq,
    input  logic [7:0]                    kb_keycode,
    output logic                          kb_clear_keycode,
    input  logic                          port_clear,
    input  logic                          port_clock_n,
    output logic [7:0]                    port_a_data,
    output logic                          irq1,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             clear_q,      clear_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]    count_q,      count_d;
    logic             overflow_q,   overflow_d;
    logic [15:0]      gap_q,        gap_d;
    logic [15:0]      hold_q,       hold_d;
    logic             clk_n_prev_q, clk_n_prev_d;
    logic [0:0]       state_q,      state_d;
    logic [7:0]       data_q,       data_d;

    logic             w_capture;
    logic             w_flush;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_load;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    // While the acknowledge is out, the receiver has not yet dropped irq,
    // so the level is ignored to avoid capturing the same code twice.
    assign w_capture    = kb_irq & ~clear_q;

    // Qualified keyboard reset: PB6 rising edge after a long enough low time.
    // The hold counter still carries its final value in the edge cycle.
    assign w_flush      = port_clock_n & ~clk_n_prev_q & (hold_q == RESET_HOLD);

    assign w_fifo_empty = (count_q == '0);
    assign w_fifo_full  = (count_q == CW'(FIFO_DEPTH));

    assign w_load       = (state_q == c_st_empty) & ~w_fifo_empty & ~port_clear
                        & port_clock_n & (gap_q == 16'd0) & ~w_flush;
    assign w_pop        = w_load;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push       = w_capture & ~w_flush & (~w_fifo_full | w_pop);
    assign w_drop       = w_capture & ~w_flush & w_fifo_full & ~w_pop;

    // ------------------------------------------------------------------
    // Acknowledge, gap and hold counters
    // ------------------------------------------------------------------
    always_comb begin
        // Every capture is acknowledged, including dropped or flushed codes.
        clear_d      = w_capture;
        clk_n_prev_d = port_clock_n;

        if (port_clear) begin
            gap_d = LOAD_GAP;
        end else if (gap_q == 16'd0) begin
            gap_d = 16'd0;
        end else begin
            gap_d = gap_q - 16'd1;
        end

        if (port_clock_n) begin
            hold_d = 16'd0;
        end else if (hold_q == RESET_HOLD) begin
            hold_d = hold_q;
        end else begin
            hold_d = hold_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
`ifdef XT_KBD_SELF_TEST_EN
            // Self-test passed code becomes the only queued entry.
            mem_d[0]   = 8'hAA;
            wr_ptr_d   = AW'(1);
            count_d    = CW'(1);
`endif
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = kb_keycode;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (w_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Latch FSM: next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (w_flush || port_clear) begin
            state_d = c_st_empty;
        end else if (w_load) begin
            state_d = c_st_full;
            data_d  = mem_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Latch FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        irq1        = 1'b0;
        port_a_data = 8'h00;
        if (state_q == c_st_full) begin
            irq1        = 1'b1;
            port_a_data = data_q;
        end
    end

    assign kb_clear_keycode = clear_q;
    assign overflow         = overflow_q;
    assign fifo_count       = count_q;

    // ------------------------------------------------------------------
    // Latch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_st_empty;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Remaining registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clear_q      <= 1'b0;
            mem_q        <= '{default: 8'h00};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            gap_q        <= 16'd0;
            hold_q       <= 16'd0;
            clk_n_prev_q <= 1'b1;
        end else begin
            clear_q      <= clear_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            gap_q        <= gap_d;
            hold_q       <= hold_d;
            clk_n_prev_q <= clk_n_prev_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xt_keyboard_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xt_keyboard_port
//  Purpose  : Directed self-checking bench for xt_keyboard_port with small
//             timing parameters (depth 4, hold 12, gap 6).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xt_keyboard_port;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [15:0] RH         = 16'd12;
    localparam logic [15:0] LG         = 16'd6;

    logic       clock;
    logic       reset_n;
    logic       kb_irq;
    logic [7:0] kb_keycode;
    logic       kb_clear_keycode;
    logic       port_clear;
    logic       port_clock_n;
    logic [7:0] port_a_data;
    logic       irq1;
    logic       overflow;
    logic [2:0] fifo_count;

    int n_checks;
    int n_fail;

    xt_keyboard_port #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_HOLD (RH),
        .LOAD_GAP   (LG)
    ) u_dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .kb_irq           (kb_irq),
        .kb_keycode       (kb_keycode),
        .kb_clear_keycode (kb_clear_keycode),
        .port_clear       (port_clear),
        .port_clock_n     (port_clock_n),
        .port_a_data      (port_a_data),
        .irq1             (irq1),
        .overflow         (overflow),
        .fifo_count       (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Receiver model: irq held two cycles, dropped after the acknowledge.
    task automatic send_code(input logic [7:0] code);
        kb_irq     = 1'b1;
        kb_keycode = code;
        tick();
        check_value("ack", 32'(kb_clear_keycode), 32'd1);
        tick();
        check_value("ack_once", 32'(kb_clear_keycode), 32'd0);
        kb_irq     = 1'b0;
    endtask

    // PB7 pulse, then expect the next code exactly LOAD_GAP+1 cycles later.
    task automatic drain_one(input logic [7:0] code);
        port_clear = 1'b1;
        tick();
        port_clear = 1'b0;
        repeat (LG) tick();
        check_value("gap_irq_low", 32'(irq1), 32'd0);
        tick();
        check_value("gap_irq_high", 32'(irq1), 32'd1);
        check_value("gap_data", 32'(port_a_data), 32'(code));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        kb_irq       = 1'b0;
        kb_keycode   = 8'h00;
        port_clear   = 1'b0;
        port_clock_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset values
        check_value("rst_ack",   32'(kb_clear_keycode), 32'd0);
        check_value("rst_data",  32'(port_a_data),      32'h00);
        check_value("rst_irq1",  32'(irq1),             32'd0);
        check_value("rst_ovf",   32'(overflow),         32'd0);
        check_value("rst_count", 32'(fifo_count),       32'd0);

        // Single key: latched two cycles after irq
        send_code(8'h1E);
        check_value("single_irq1",  32'(irq1),        32'd1);
        check_value("single_data",  32'(port_a_data), 32'h1E);
        check_value("single_count", 32'(fifo_count),  32'd0);

        // Handshake: three queued codes delivered in order with gap timing
        port_clear = 1'b1;
        tick();
        check_value("clr_irq1", 32'(irq1),        32'd0);
        check_value("clr_data", 32'(port_a_data), 32'h00);
        send_code(8'h10);
        send_code(8'h90);
        send_code(8'h11);
        check_value("hs_count", 32'(fifo_count), 32'd3);
        drain_one(8'h10);
        drain_one(8'h90);
        drain_one(8'h11);
        port_clear = 1'b1;
        tick();
        check_value("hs_empty", 32'(fifo_count), 32'd0);

        // Overflow: depth+2 codes with PB7 held, first depth drain in order
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            send_code(8'h20 + 8'(i));
        end
        check_value("ovf_count", 32'(fifo_count), 32'(FIFO_DEPTH));
        check_value("ovf_flag",  32'(overflow),   32'd1);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drain_one(8'h20 + 8'(i));
        end
        port_clear = 1'b1;
        tick();
        check_value("ovf_drained", 32'(fifo_count), 32'd0);
        check_value("ovf_sticky",  32'(overflow),   32'd1);

        // Keyboard reset with two codes queued
        send_code(8'h50);
        send_code(8'h51);
        check_value("kr_count_pre", 32'(fifo_count), 32'd2);
        port_clock_n = 1'b0;
        port_clear   = 1'b0;
        repeat (RH) tick();
        check_value("kr_blocked", 32'(irq1),       32'd0);
        check_value("kr_count_low", 32'(fifo_count), 32'd2);
        port_clock_n = 1'b1;
        tick();
`ifdef XT_KBD_SELF_TEST_EN
        check_value("kr_count_post", 32'(fifo_count), 32'd1);
`else
        check_value("kr_count_post", 32'(fifo_count), 32'd0);
`endif
        check_value("kr_ovf_clr", 32'(overflow), 32'd0);
        check_value("kr_irq1",    32'(irq1),     32'd0);
        tick();
`ifdef XT_KBD_SELF_TEST_EN
        check_value("kr_aa_irq1", 32'(irq1),        32'd1);
        check_value("kr_aa_data", 32'(port_a_data), 32'hAA);
`else
        check_value("kr_off_irq1", 32'(irq1),        32'd0);
        check_value("kr_off_data", 32'(port_a_data), 32'h00);
`endif
        check_value("kr_count_end", 32'(fifo_count), 32'd0);

        // Short PB6 pulse: no flush, load resumes on release
        port_clear = 1'b1;
        tick();
        send_code(8'h33);
        port_clock_n = 1'b0;
        port_clear   = 1'b0;
        repeat (RH - 16'd1) tick();
        check_value("sp_blocked", 32'(irq1),       32'd0);
        check_value("sp_count",   32'(fifo_count), 32'd1);
        port_clock_n = 1'b1;
        tick();
        check_value("sp_irq1",  32'(irq1),        32'd1);
        check_value("sp_data",  32'(port_a_data), 32'h33);
        check_value("sp_count_after", 32'(fifo_count), 32'd0);

        // Fill FIFO behind a full latch (one dropped), then async reset
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            send_code(8'h40 + 8'(i));
        end
        check_value("ar_count_pre", 32'(fifo_count), 32'(FIFO_DEPTH));
        check_value("ar_ovf_pre",   32'(overflow),   32'd1);
        check_value("ar_irq_pre",   32'(irq1),       32'd1);
        reset_n = 1'b0;
        #2;
        check_value("ar_ack",   32'(kb_clear_keycode), 32'd0);
        check_value("ar_data",  32'(port_a_data),      32'h00);
        check_value("ar_irq1",  32'(irq1),             32'd0);
        check_value("ar_ovf",   32'(overflow),         32'd0);
        check_value("ar_count", 32'(fifo_count),       32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_value("ar_count_rel", 32'(fifo_count), 32'd0);
        check_value("ar_irq_rel",   32'(irq1),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
